// File: rtl/led_matrix_scan.sv
// Avalon-MM slave holding a double-buffered LED frame; scans the front buffer row by row
// on scan_tick, with blanking between rows and an interrupt at frame end.
module led_matrix_scan #(
    parameter int ROWS         = 8,
    parameter int COLS         = 8,
    parameter int BLANK_CYCLES = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            chipselect,
    input  logic [3:0]      address,
    input  logic            write_n,
    input  logic [15:0]     writedata,
    output logic [15:0]     readdata,
    input  logic            scan_tick,
    output logic [ROWS-1:0] row_sel_n,
    output logic [COLS-1:0] col_out,
    output logic            irq,
    output logic [1:0]      o_dbg_state
);

    localparam int              BW         = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [BW-1:0]   BLANK_LAST = BW'(BLANK_CYCLES - 1);
    localparam logic [2:0]      LAST_ROW   = 3'(ROWS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } state_t;

    state_t          r_state;
    logic [BW-1:0]   r_blank_cnt;
    logic [2:0]      r_cur_row;
    logic [2:0]      r_next_row;
    logic [COLS-1:0] r_buf0 [ROWS];
    logic [COLS-1:0] r_buf1 [ROWS];
    logic            r_front_sel;
    logic            r_enable;
    logic            r_irq_en;
    logic            r_frame_done;
    logic            r_swap_pending;

    logic            w_wr;
    logic            w_wr_back;
    logic            w_wr_ctrl;
    logic            w_wr_stat;
    logic            w_frame_end;
    logic            w_enable_nxt;
    logic            w_irq_en_nxt;
    logic            w_frame_done_nxt;
    logic            w_swap_pending_nxt;
    logic [2:0]      w_addr_row;
    logic [COLS-1:0] w_back_rd;
    logic [COLS-1:0] w_front_cur;
    logic [COLS-1:0] w_front_next;
    logic [15:0]     w_rdata;

    function automatic logic [ROWS-1:0] row_onehot_n(input logic [2:0] idx);
        return ~(ROWS'(1) << idx);
    endfunction

    assign w_addr_row = address[2:0];
    assign w_wr       = chipselect & ~write_n;
    assign w_wr_back  = w_wr && (address < 4'(ROWS));
    assign w_wr_ctrl  = w_wr && (address == 4'd8);
    assign w_wr_stat  = w_wr && (address == 4'd9);

    assign w_frame_end = (r_state == ST_DRIVE) && r_enable && scan_tick && (r_cur_row == LAST_ROW);

    // Frame-end set beats a STATUS clear; a new swap_req survives the consumption of the old one.
    assign w_enable_nxt       = w_wr_ctrl ? writedata[0] : r_enable;
    assign w_irq_en_nxt       = w_wr_ctrl ? writedata[1] : r_irq_en;
    assign w_frame_done_nxt   = w_frame_end | (r_frame_done & ~w_wr_stat);
    assign w_swap_pending_nxt = (w_wr_ctrl & writedata[2]) | (r_swap_pending & ~w_frame_end);

    assign w_back_rd    = r_front_sel ? r_buf0[w_addr_row] : r_buf1[w_addr_row];
    assign w_front_cur  = r_front_sel ? r_buf1[r_cur_row]  : r_buf0[r_cur_row];
    assign w_front_next = r_front_sel ? r_buf1[r_next_row] : r_buf0[r_next_row];

    assign o_dbg_state = r_state;

    always_comb begin
        w_rdata = '0;
        if (address < 4'(ROWS)) begin
            w_rdata[COLS-1:0] = w_back_rd;
        end else if (address == 4'd8) begin
            w_rdata[1:0] = {r_irq_en, r_enable};
        end else if (address == 4'd9) begin
            w_rdata[0]   = r_frame_done;
            w_rdata[1]   = r_swap_pending;
            w_rdata[6:4] = r_cur_row;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ROWS; i++) begin
                r_buf0[i] <= '0;
                r_buf1[i] <= '0;
            end
            r_front_sel    <= 1'b0;
            r_enable       <= 1'b0;
            r_irq_en       <= 1'b0;
            r_frame_done   <= 1'b0;
            r_swap_pending <= 1'b0;
            irq            <= 1'b0;
            readdata       <= '0;
        end else begin
            // Bus writes always target the pre-swap back buffer.
            if (w_wr_back) begin
                if (r_front_sel) begin
                    r_buf0[w_addr_row] <= writedata[COLS-1:0];
                end else begin
                    r_buf1[w_addr_row] <= writedata[COLS-1:0];
                end
            end
            if (w_frame_end && r_swap_pending) begin
                r_front_sel <= ~r_front_sel;
            end
            r_enable       <= w_enable_nxt;
            r_irq_en       <= w_irq_en_nxt;
            r_frame_done   <= w_frame_done_nxt;
            r_swap_pending <= w_swap_pending_nxt;
            irq            <= w_frame_done_nxt & w_irq_en_nxt;
            readdata       <= w_rdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_blank_cnt <= '0;
            r_cur_row   <= '0;
            r_next_row  <= '0;
            row_sel_n   <= '1;
            col_out     <= '0;
        end else if (!r_enable) begin
            r_state     <= ST_IDLE;
            r_blank_cnt <= '0;
            r_cur_row   <= '0;
            r_next_row  <= '0;
            row_sel_n   <= '1;
            col_out     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    row_sel_n <= '1;
                    col_out   <= '0;
                    if (scan_tick) begin
                        r_state     <= ST_BLANK;
                        r_blank_cnt <= '0;
                        r_cur_row   <= '0;
                        r_next_row  <= '0;
                    end
                end
                ST_BLANK: begin
                    if (r_blank_cnt == BLANK_LAST) begin
                        r_state   <= ST_DRIVE;
                        r_cur_row <= r_next_row;
                        row_sel_n <= row_onehot_n(r_next_row);
                        col_out   <= w_front_next;
                    end else begin
                        r_blank_cnt <= r_blank_cnt + 1'b1;
                    end
                end
                ST_DRIVE: begin
                    if (scan_tick) begin
                        r_state     <= ST_BLANK;
                        r_blank_cnt <= '0;
                        r_next_row  <= (r_cur_row == LAST_ROW) ? 3'd0 : r_cur_row + 3'd1;
                        row_sel_n   <= '1;
                        col_out     <= '0;
                    end else begin
                        row_sel_n <= row_onehot_n(r_cur_row);
                        col_out   <= w_front_cur;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    row_sel_n <= '1;
                    col_out   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_matrix_scan.sv
// Directed + randomized bench for led_matrix_scan; a frame/buffer model tracks what the
// matrix pins and registers must show after every bus access and scan tick.
module tb_led_matrix_scan;

    localparam int ROWS = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        chipselect;
    logic [3:0]  address;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic        scan_tick;
    logic [7:0]  row_sel_n;
    logic [7:0]  col_out;
    logic        irq;
    logic [1:0]  dbg_state;

    led_matrix_scan #(.ROWS(8), .COLS(8), .BLANK_CYCLES(4)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .chipselect  (chipselect),
        .address     (address),
        .write_n     (write_n),
        .writedata   (writedata),
        .readdata    (readdata),
        .scan_tick   (scan_tick),
        .row_sel_n   (row_sel_n),
        .col_out     (col_out),
        .irq         (irq),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: two frame buffers, which one is displayed, and the scan position.
    logic [7:0] m_buf [2][8];
    int         m_front;
    bit         m_enable, m_irq_en, m_pending, m_done, m_active;
    int         m_cur, m_next;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int b = 0; b < 2; b++)
            for (int r = 0; r < 8; r++) m_buf[b][r] = 8'h00;
        m_front = 0; m_enable = 0; m_irq_en = 0; m_pending = 0; m_done = 0;
        m_active = 0; m_cur = 0; m_next = 0;
    endtask

    function automatic logic [15:0] model_read(input int a);
        logic [15:0] v;
        v = 16'h0;
        if (a < ROWS) v[7:0] = m_buf[1-m_front][a];
        else if (a == 8) v[1:0] = {m_irq_en, m_enable};
        else if (a == 9) begin
            v[0] = m_done; v[1] = m_pending; v[6:4] = 3'(m_cur);
        end
        return v;
    endfunction

    task automatic model_write(input int a, input logic [15:0] d);
        if (a < ROWS) m_buf[1-m_front][a] = d[7:0];
        else if (a == 8) begin
            m_enable = d[0]; m_irq_en = d[1];
            if (d[2]) m_pending = 1;
        end else if (a == 9) m_done = 0;
    endtask

    task automatic check_out(input string tag, input bit lit);
        logic [7:0] er, ec;
        er = 8'hFF; ec = 8'h00;
        if (lit) begin
            er = ~(8'h01 << m_cur);
            ec = m_buf[m_front][m_cur];
        end
        check({tag, "_row"}, row_sel_n, er);
        check({tag, "_col"}, col_out, ec);
        check({tag, "_irq"}, irq, m_done & m_irq_en);
    endtask

    task automatic wr(input int a, input logic [15:0] d);
        bit was_active;
        was_active = m_active;
        @(negedge clk);
        chipselect = 1; write_n = 0; address = 4'(a); writedata = d;
        model_write(a, d);
        @(negedge clk);
        chipselect = 0; write_n = 1;
        check_out("wr", m_active);
        if (was_active && !m_enable) begin
            @(negedge clk);
            m_active = 0; m_cur = 0;
            check_out("disable", 0);
        end
    endtask

    task automatic rd(input int a);
        logic [15:0] exp;
        @(negedge clk);
        chipselect = 1; write_n = 1; address = 4'(a);
        exp = model_read(a);
        @(negedge clk);
        chipselect = 0;
        check($sformatf("rd%0d", a), readdata, exp);
    endtask

    // One scan tick, optionally with a bus write in the same clock and extra ticks inside BLANK.
    task automatic do_tick(input bit co_wr, input int co_addr, input logic [15:0] co_data,
                           input bit blank_ticks, input int gap);
        bit started, fe, pend_before, pend_set;
        @(negedge clk);
        scan_tick = 1;
        if (co_wr) begin
            chipselect = 1; write_n = 0; address = 4'(co_addr); writedata = co_data;
        end
        started = 0; fe = 0;
        pend_before = m_pending;
        pend_set = co_wr && (co_addr == 8) && co_data[2];
        if (m_enable) begin
            started = 1;
            if (!m_active) begin
                m_active = 1; m_cur = 0; m_next = 0;
            end else begin
                fe = (m_cur == ROWS - 1);
                m_next = fe ? 0 : m_cur + 1;
            end
        end
        if (co_wr) model_write(co_addr, co_data);
        if (fe) begin
            m_done = 1;
            if (pend_before) begin
                m_front = 1 - m_front;
                m_pending = pend_set;
            end
        end
        @(negedge clk);
        scan_tick = 0; chipselect = 0; write_n = 1;
        if (!started) begin
            check_out("ignored", 0);
        end else begin
            for (int i = 0; i < 4; i++) begin
                check_out($sformatf("blank%0d", i), 0);
                if (blank_ticks && (i == 0 || i == 2)) scan_tick = 1;
                @(negedge clk);
                scan_tick = 0;
            end
            m_cur = m_next;
            check_out("lit", 1);
            repeat (gap) @(negedge clk);
            check_out("hold", 1);
        end
    endtask

    task automatic advance_to(input int row);
        for (int k = 0; k <= ROWS; k++)
            if (m_cur != row || !m_active) do_tick(0, 0, 16'h0, 0, $urandom_range(1, 4));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev_row;
        reset_n = 0; chipselect = 0; write_n = 1; address = 4'd0; writedata = 16'h0; scan_tick = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_out("reset", 0);
        check("reset_rdata", readdata, 16'h0);
        reset_n = 1;
        rd(9);

        // Back buffer gets a walking one, then swap + enable; first frame still shows zeros.
        for (int r = 0; r < ROWS; r++) wr(r, 16'(8'h01 << r));
        wr(8, 16'h0005);
        rd(9);
        rd(3);
        for (int t = 0; t < 10; t++) begin
            do_tick(0, 0, 16'h0, 0, 14);
            if (t == 8) begin
                check("t2_row0_sel", row_sel_n, 8'hFE);
                check("t2_row0_col", col_out, 8'h01);
            end
        end

        // irq at frame end; STATUS write on that same cycle loses to the set.
        wr(8, 16'h0003);
        for (int r = 0; r < ROWS; r++) wr(r, 16'($urandom_range(0, 255)));
        advance_to(ROWS - 1);
        do_tick(1, 9, 16'h0, 0, 3);
        check("t3_irq_set", irq, 1'b1);
        rd(9);
        wr(9, 16'h0000);
        check("t3_irq_clr", irq, 1'b0);

        // Ticks landing inside BLANK must not advance the row.
        prev_row = m_cur;
        do_tick(0, 0, 16'h0, 1, 3);
        rd(9);
        check("t4_step", 32'(m_cur), 32'((prev_row + 1) % ROWS));
        do_tick(0, 0, 16'h0, 1, 2);

        // swap_req coincident with frame end stays pending for the next frame end.
        advance_to(ROWS - 1);
        do_tick(1, 8, 16'h0007, 0, 2);
        rd(9);
        check("t6_pending", readdata[1], 1'b1);
        for (int r = 1; r < ROWS; r++) wr(r, 16'($urandom_range(0, 255)));
        advance_to(ROWS - 1);
        do_tick(1, 0, 16'($urandom_range(0, 255)), 0, 2);
        rd(9);
        for (int r = 0; r < 3; r++) do_tick(0, 0, 16'h0, 0, 1);

        // Disable mid-scan, then restart from row 0.
        wr(8, 16'h0004);
        wr(8, 16'h0003);
        advance_to(5);
        wr(8, 16'h0002);
        rd(9);
        do_tick(0, 0, 16'h0, 0, 1);
        wr(8, 16'h0003);
        do_tick(0, 0, 16'h0, 0, 2);
        rd(9);

        // Randomized mix of ticks, bus writes and reads.
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 3))
                0: begin
                    int sel;
                    sel = $urandom_range(0, 3);
                    if (sel == 0)
                        do_tick(1, $urandom_range(0, 7), 16'($urandom), $urandom_range(0, 1), $urandom_range(0, 5));
                    else if (sel == 1)
                        do_tick(1, 8, {13'h0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1},
                                $urandom_range(0, 1), $urandom_range(0, 5));
                    else if (sel == 2)
                        do_tick(1, 9, 16'($urandom), 0, $urandom_range(0, 5));
                    else
                        do_tick(0, 0, 16'h0, $urandom_range(0, 1), $urandom_range(0, 5));
                end
                1: wr($urandom_range(0, 7), 16'($urandom));
                2: rd($urandom_range(0, 15));
                default: wr($urandom_range(9, 15), 16'($urandom));
            endcase
        end

        // Asynchronous reset in the middle of a lit row.
        advance_to(2);
        @(negedge clk);
        #2 reset_n = 0;
        #1;
        model_reset();
        check_out("async_rst", 0);
        check("async_rst_rdata", readdata, 16'h0);
        @(negedge clk);
        reset_n = 1;
        rd(9);
        rd(8);
        rd(0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
